// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - byte-to-word deserializer with valid/ready on both sides
//
// Packs SIZE bytes, one per byte handshake, into one word. The finished word is
// held in word_out with word_valid=1 until it is consumed through word_ready.
//
// Parameters:
//   SIZE       bytes per word (>= 1)
//   MSB_FIRST  0: first byte lands in word_out[7:0]; 1: first byte lands in the top byte
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   clear       in   synchronous flush of the partial word and any held word
//   byte_valid  in   byte_in is valid
//   byte_in     in   incoming byte
//   byte_ready  out  byte_in is accepted this cycle
//   word_valid  out  word_out holds a complete word
//   word_out    out  packed word
//   word_ready  in   downstream consumes word_out this cycle
//   byte_count  out  bytes collected for the partial word
module byte_packer #(
  parameter int SIZE      = 2,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = $clog2(SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_ready,
  output logic              word_valid,
  output logic [SIZE*8-1:0] word_out,
  input  logic              word_ready,
  output logic [CW-1:0]     byte_count
);

  typedef enum logic {FILL, FULL} state_t;

  state_t            state_q, state_d;
  logic [SIZE*8-1:0] sr, sr_next;
  logic              accept, take, complete;
  logic [CW-1:0]     base;

  assign word_valid = (state_q == FULL);
  assign byte_ready = !rst && !clear && (!word_valid || word_ready);
  assign accept     = byte_valid && byte_ready;
  assign take       = word_valid && word_ready;

  // An accept while FULL is necessarily paired with a take, so that byte is
  // byte 0 of the next word regardless of byte_count.
  assign base     = word_valid ? '0 : byte_count;
  assign complete = accept && (base == CW'(SIZE - 1));

  generate
    if (SIZE == 1) begin : g_single
      assign sr_next = byte_in;
    end else if (MSB_FIRST) begin : g_msb
      assign sr_next = {sr[SIZE*8-9:0], byte_in};
    end else begin : g_lsb
      assign sr_next = {byte_in, sr[SIZE*8-1:8]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL;
    end else if (complete) begin
      state_d = FULL;
    end else if (take) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      sr         <= '0;
      word_out   <= '0;
      byte_count <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        byte_count <= '0;
      end else if (accept) begin
        sr         <= sr_next;
        byte_count <= complete ? '0 : base + CW'(1);
        if (complete) begin
          word_out <= sr_next;
        end
      end else if (take) begin
        byte_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - self-checking bench for byte_packer across four configurations
module tb_byte_packer;

  logic       clk = 1'b0;
  logic       rst, clear, byte_valid, word_ready;
  logic [7:0] byte_in;

  always #5 clk = ~clk;

  // Instance k: 0 -> SIZE 2 LSB-first, 1 -> SIZE 2 MSB-first, 2 -> SIZE 4, 3 -> SIZE 1
  int SZ [4] = '{2, 2, 4, 1};
  bit MF [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic        br   [4];
  logic        wv   [4];
  logic [31:0] wo_a [4];
  logic [31:0] bc_a [4];

  logic [15:0] wo0, wo1;
  logic [31:0] wo2;
  logic [7:0]  wo3;
  logic [1:0]  bc0, bc1;
  logic [2:0]  bc2;
  logic [0:0]  bc3;

  byte_packer #(.SIZE(2), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(br[0]), .word_valid(wv[0]), .word_out(wo0), .word_ready(word_ready),
    .byte_count(bc0));
  byte_packer #(.SIZE(2), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(br[1]), .word_valid(wv[1]), .word_out(wo1), .word_ready(word_ready),
    .byte_count(bc1));
  byte_packer #(.SIZE(4), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(br[2]), .word_valid(wv[2]), .word_out(wo2), .word_ready(word_ready),
    .byte_count(bc2));
  byte_packer #(.SIZE(1), .MSB_FIRST(1'b0)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(br[3]), .word_valid(wv[3]), .word_out(wo3), .word_ready(word_ready),
    .byte_count(bc3));

  assign wo_a[0] = {16'h0, wo0};
  assign wo_a[1] = {16'h0, wo1};
  assign wo_a[2] = wo2;
  assign wo_a[3] = {24'h0, wo3};
  assign bc_a[0] = {30'h0, bc0};
  assign bc_a[1] = {30'h0, bc1};
  assign bc_a[2] = {29'h0, bc2};
  assign bc_a[3] = {31'h0, bc3};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes collected into a list, packed by position once SIZE arrive.
  logic        held_m [4];
  logic [31:0] word_m [4];
  int          cnt_m  [4];
  logic [7:0]  pb_m   [4][4];

  task automatic model_update();
    logic rdy;
    for (int k = 0; k < 4; k++) begin
      rdy = !rst && !clear && (!held_m[k] || word_ready);
      if (rst) begin
        held_m[k] = 1'b0;
        word_m[k] = 32'h0;
        cnt_m[k]  = 0;
      end else if (clear) begin
        held_m[k] = 1'b0;
        cnt_m[k]  = 0;
      end else begin
        if (held_m[k] && word_ready) held_m[k] = 1'b0;
        if (byte_valid && rdy) begin
          pb_m[k][cnt_m[k]] = byte_in;
          cnt_m[k]++;
          if (cnt_m[k] == SZ[k]) begin
            word_m[k] = 32'h0;
            for (int i = 0; i < SZ[k]; i++)
              word_m[k] = word_m[k] | (32'(pb_m[k][i]) << (8 * (MF[k] ? SZ[k] - 1 - i : i)));
            held_m[k] = 1'b1;
            cnt_m[k]  = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("byte_ready%0d", k), 32'(br[k]),
            32'(!rst && !clear && (!held_m[k] || word_ready)));
      check($sformatf("word_valid%0d", k), 32'(wv[k]), 32'(held_m[k]));
      check($sformatf("byte_count%0d", k), bc_a[k], 32'(cnt_m[k]));
      if (held_m[k]) check($sformatf("word_out%0d", k), wo_a[k], word_m[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      held_m[k] = 1'b0;
      word_m[k] = 32'h0;
      cnt_m[k]  = 0;
    end
    rst = 1'b1; clear = 1'b0; byte_valid = 1'b0; byte_in = 8'h0; word_ready = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    for (int k = 0; k < 4; k++) check($sformatf("reset_word_out%0d", k), wo_a[k], 32'h0);
    rst = 1'b0;

    // Back-to-back AA, BB with the sink always ready
    word_ready = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
    cycle();
    check("t2_count_after_first", bc_a[1], 32'd1);
    byte_in = 8'hBB;
    cycle();
    byte_valid = 1'b0;
    check("t1_valid", 32'(wv[0]), 32'd1);
    check("t1_word", wo_a[0], 32'hBBAA);
    check("t2_word", wo_a[1], 32'hAABB);
    check("t2_count_after_word", bc_a[1], 32'd0);
    cycle();

    // Held word under backpressure, then take with a simultaneous byte
    rst = 1'b1; cycle(); rst = 1'b0;
    word_ready = 1'b0; byte_valid = 1'b1; byte_in = 8'h11;
    cycle();
    byte_in = 8'h22;
    cycle();
    byte_in = 8'h33;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_stall_ready", 32'(br[0]), 32'd0);
      check("t3_stall_word", wo_a[0], 32'h2211);
    end
    word_ready = 1'b1;
    cycle();
    check("t3_count_after_take", bc_a[0], 32'd1);
    byte_in = 8'h44;
    cycle();
    byte_valid = 1'b0;
    check("t3_second_word", wo_a[0], 32'h4433);
    check("t3_second_valid", 32'(wv[0]), 32'd1);

    // Partial word flushed by clear, then a full SIZE=4 word
    rst = 1'b1; cycle(); rst = 1'b0;
    word_ready = 1'b0; byte_valid = 1'b1;
    byte_in = 8'h01; cycle();
    byte_in = 8'h02; cycle();
    clear = 1'b1; byte_in = 8'h99; cycle();
    clear = 1'b0;
    check("t4_count_after_clear", bc_a[2], 32'd0);
    byte_in = 8'h10; cycle();
    byte_in = 8'h20; cycle();
    byte_in = 8'h30; cycle();
    check("t4_not_yet_valid", 32'(wv[2]), 32'd0);
    byte_in = 8'h40; cycle();
    byte_valid = 1'b0;
    check("t4_valid", 32'(wv[2]), 32'd1);
    check("t4_word", wo_a[2], 32'h40302010);

    // Reset while a word is held
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t5_valid", 32'(wv[2]), 32'd0);
    check("t5_count", bc_a[2], 32'd0);
    check("t5_word", wo_a[2], 32'h0);

    // SIZE=1 streaming without bubbles
    word_ready = 1'b1; byte_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      byte_in = 8'(i);
      cycle();
      check("t6_valid", 32'(wv[3]), 32'd1);
      check("t6_word", wo_a[3], 32'(i));
    end
    byte_valid = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      clear      = ($urandom_range(0, 49) == 0);
      byte_valid = ($urandom_range(0, 9) < 7);
      word_ready = ($urandom_range(0, 9) < 6);
      byte_in    = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
